cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 37 +++
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle of requester handshake signals and the registered CDB broadcast for cdb_arbiter.
`ifndef NUM_SRBITS
`define NUM_SRBITS 4
`endif

interface cdb_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned TagW = `NUM_SRBITS;
    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic            valid;
        logic [TagW-1:0] tag;
        logic [31:0]     data;
    } cdb_bus_t;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*TagW-1:0] req_tag;
    logic [NUM_REQ*32-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    cdb_bus_t                cdb_o;
    logic [IdW-1:0]          grant_id_o;
    logic                    err_o;

    // Requester side (functional units).
    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_o, grant_id_o, err_o
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_o, grant_id_o, err_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: requester 0 gets bounded priority, the rest share a round-robin
// pointer; the winner's tag/data is broadcast one cycle later.
`ifndef NUM_SRBITS
`define NUM_SRBITS 4
`endif

module cdb_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned PRIO_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restore,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned TagW = `NUM_SRBITS;
    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (PRIO_LIMIT > 0) ? $clog2(PRIO_LIMIT + 1) : 1;
    localparam logic [NUM_REQ-1:0] Bit0 = NUM_REQ'(1);

    logic               cdb_valid_q;
    logic [TagW-1:0]    cdb_tag_q;
    logic [31:0]        cdb_data_q;
    logic [IdW-1:0]     grant_id_q;
    logic               err_q;
    logic [IdW-1:0]     rr_ptr_q;
    logic [CntW-1:0]    prio_cnt_q;

    logic [NUM_REQ-1:0] tag_nz;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] rr_mask;
    logic               zero_tag;
    logic               prio_cap;
    logic               others;
    logic               rr_found;
    logic [IdW-1:0]     rr_idx;
    logic [IdW-1:0]     j_idx;
    int unsigned        j;
    logic               gnt_prio;
    logic               gnt_rr;
    logic               gnt_any;
    logic [IdW-1:0]     gnt_id;
    logic [TagW-1:0]    sel_tag;
    logic [31:0]        sel_data;

    always_comb begin
        tag_nz = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            tag_nz[i] = |bus.req_tag[i*TagW +: TagW];
        end
        elig     = bus.req_valid & tag_nz;
        zero_tag = |(bus.req_valid & ~tag_nz);
        prio_cap = (prio_cnt_q == CntW'(PRIO_LIMIT));
        others   = |(elig & ~Bit0);

        // Requester 0 drops out of the rotating search only once its budget is spent.
        rr_mask  = prio_cap ? (elig & ~Bit0) : elig;
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        j_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j     = (32'(rr_ptr_q) + k) % NUM_REQ;
            j_idx = IdW'(j);
            if (!rr_found && rr_mask[j_idx]) begin
                rr_found = 1'b1;
                rr_idx   = j_idx;
            end
        end

        gnt_prio = rst & ~restore & elig[0] & (~prio_cap | ~others);
        gnt_rr   = rst & ~restore & ~gnt_prio & rr_found;
        gnt_any  = gnt_prio | gnt_rr;
        gnt_id   = gnt_prio ? '0 : rr_idx;

        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_id == IdW'(i)) begin
                sel_tag  = bus.req_tag[i*TagW +: TagW];
                sel_data = bus.req_data[i*32 +: 32];
            end
        end
    end

    assign bus.req_ready  = gnt_any ? (Bit0 << gnt_id) : '0;
    assign bus.cdb_o      = {cdb_valid_q, cdb_tag_q, cdb_data_q};
    assign bus.grant_id_o = grant_id_q;
    assign bus.err_o      = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            grant_id_q  <= '0;
            err_q       <= 1'b0;
            rr_ptr_q    <= '0;
            prio_cnt_q  <= '0;
        end else begin
            cdb_valid_q <= gnt_any;
            if (gnt_any) begin
                cdb_tag_q  <= sel_tag;
                cdb_data_q <= sel_data;
                grant_id_q <= gnt_id;
            end
            if (zero_tag) begin
                err_q <= 1'b1;
            end
            if (restore) begin
                prio_cnt_q <= '0;
            end else if (gnt_prio) begin
                if (!prio_cap) begin
                    prio_cnt_q <= prio_cnt_q + CntW'(1);
                end
            end else if (gnt_rr) begin
                prio_cnt_q <= '0;
            end
            // Only a rotating-search grant advances the pointer.
            if (gnt_rr) begin
                rr_ptr_q <= (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + IdW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter (NUM_REQ=4, PRIO_LIMIT=3, 4-bit tags).
`ifndef NUM_SRBITS
`define NUM_SRBITS 4
`endif

module tb_cdb_arbiter;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    logic restore;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(NR)) bus ();

    cdb_arbiter #(
        .NUM_REQ   (NR),
        .PRIO_LIMIT(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .restore(restore),
        .bus    (bus)
    );

    typedef struct {
        logic        rst;
        logic        restore;
        logic [3:0]  valid;
        logic [15:0] tags;
        logic [3:0]  ready;
        logic        cv;
        logic [3:0]  ctag;
        logic [1:0]  cid;
        logic        err;
    } vec_t;

    vec_t vecs[25];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic rs, logic [3:0] v, logic [15:0] t, logic [3:0] rdy,
                                logic cv, logic [3:0] ct, logic [1:0] ci, logic e);
        vec_t x;
        x.rst = r; x.restore = rs; x.valid = v; x.tags = t; x.ready = rdy;
        x.cv = cv; x.ctag = ct; x.cid = ci; x.err = e;
        return x;
    endfunction

    function automatic logic [31:0] fu_data(int i, logic [3:0] tag);
        return 32'hC0DE_0000 | (32'(i) << 8) | 32'(tag);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic rs, logic [3:0] v, logic [15:0] t);
        rst           = r;
        restore       = rs;
        bus.req_valid = v;
        bus.req_tag   = t;
        for (int i = 0; i < NR; i++) bus.req_data[i*32 +: 32] = fu_data(i, t[i*4 +: 4]);
    endtask

    initial begin
        rst = 1'b0;
        restore = 1'b0;
        bus.req_valid = '0;
        bus.req_tag = '0;
        bus.req_data = '0;

        // rst restore valid tags ready | after edge: cdb valid, tag, id, err
        vecs[0]  = mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 0, 4'd0, 2'd0, 0);
        vecs[1]  = mk(1, 0, 4'b0100, 16'h0500, 4'b0100, 1, 4'd5, 2'd2, 0);
        vecs[2]  = mk(1, 0, 4'b1010, 16'h3020, 4'b1000, 1, 4'd3, 2'd3, 0);
        vecs[3]  = mk(1, 0, 4'b0000, 16'h0000, 4'b0000, 0, 4'd3, 2'd3, 0);
        vecs[4]  = mk(1, 0, 4'b1110, 16'h3210, 4'b0010, 1, 4'd1, 2'd1, 0);
        vecs[5]  = mk(1, 0, 4'b1110, 16'h3210, 4'b0100, 1, 4'd2, 2'd2, 0);
        vecs[6]  = mk(1, 0, 4'b1110, 16'h3210, 4'b1000, 1, 4'd3, 2'd3, 0);
        vecs[7]  = mk(1, 0, 4'b1110, 16'h3210, 4'b0010, 1, 4'd1, 2'd1, 0);
        vecs[8]  = mk(1, 0, 4'b0011, 16'h0021, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[9]  = mk(1, 0, 4'b0011, 16'h0021, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[10] = mk(1, 0, 4'b0011, 16'h0021, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[11] = mk(1, 0, 4'b0011, 16'h0021, 4'b0010, 1, 4'd2, 2'd1, 0);
        vecs[12] = mk(1, 0, 4'b0011, 16'h0021, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[13] = mk(1, 0, 4'b0001, 16'h0001, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[14] = mk(1, 0, 4'b0001, 16'h0001, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[15] = mk(1, 0, 4'b0001, 16'h0001, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[16] = mk(1, 0, 4'b0001, 16'h0001, 4'b0001, 1, 4'd1, 2'd0, 0);
        vecs[17] = mk(1, 0, 4'b1000, 16'h7000, 4'b1000, 1, 4'd7, 2'd3, 0);
        vecs[18] = mk(1, 1, 4'b1111, 16'h7654, 4'b0000, 0, 4'd7, 2'd3, 0);
        vecs[19] = mk(1, 0, 4'b1111, 16'h7654, 4'b0001, 1, 4'd4, 2'd0, 0);
        vecs[20] = mk(1, 0, 4'b1110, 16'h7650, 4'b0010, 1, 4'd5, 2'd1, 0);
        vecs[21] = mk(1, 0, 4'b0010, 16'h0000, 4'b0000, 0, 4'd5, 2'd1, 1);
        vecs[22] = mk(1, 0, 4'b1111, 16'h4321, 4'b0001, 1, 4'd1, 2'd0, 1);
        vecs[23] = mk(0, 0, 4'b1111, 16'h4321, 4'b0000, 0, 4'd0, 2'd0, 0);
        vecs[24] = mk(1, 0, 4'b1111, 16'h4321, 4'b0001, 1, 4'd1, 2'd0, 0);

        @(posedge clk);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].restore, vecs[k].valid, vecs[k].tags);
            #1;
            chk($sformatf("v%0d ready", k), 32'(bus.req_ready), 32'(vecs[k].ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d cdb_valid", k), 32'(bus.cdb_o.valid), 32'(vecs[k].cv));
            chk($sformatf("v%0d cdb_tag", k), 32'(bus.cdb_o.tag), 32'(vecs[k].ctag));
            chk($sformatf("v%0d grant_id", k), 32'(bus.grant_id_o), 32'(vecs[k].cid));
            chk($sformatf("v%0d err", k), 32'(bus.err_o), 32'(vecs[k].err));
            if (vecs[k].cv)
                chk($sformatf("v%0d cdb_data", k), bus.cdb_o.data,
                    fu_data(int'(vecs[k].cid), vecs[k].ctag));
        end

        // Zero-tag request is never granted and err stays set.
        @(negedge clk);
        drive(1, 0, 4'b0010, 16'h0000);
        #1;
        chk("ztag ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ztag cdb_valid", 32'(bus.cdb_o.valid), 32'd0);
        chk("ztag err", 32'(bus.err_o), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1, 0, 4'b0000, 16'h0000);
            @(posedge clk);
            #1;
            chk($sformatf("ztag err hold %0d", c), 32'(bus.err_o), 32'd1);
        end

        // Reset, then a single request with explicit data, then hold and pointer follow-up.
        @(negedge clk);
        drive(0, 0, 4'b0000, 16'h0000);
        @(posedge clk);
        #1;
        chk("rst err clear", 32'(bus.err_o), 32'd0);
        @(negedge clk);
        drive(1, 0, 4'b0100, 16'h0500);
        bus.req_data[2*32 +: 32] = 32'hDEAD_BEEF;
        #1;
        chk("single ready", 32'(bus.req_ready), 32'b0100);
        @(posedge clk);
        #1;
        chk("single cdb_valid", 32'(bus.cdb_o.valid), 32'd1);
        chk("single cdb_tag", 32'(bus.cdb_o.tag), 32'd5);
        chk("single cdb_data", bus.cdb_o.data, 32'hDEAD_BEEF);
        chk("single grant_id", 32'(bus.grant_id_o), 32'd2);
        @(negedge clk);
        drive(1, 0, 4'b0000, 16'h0000);
        @(posedge clk);
        #1;
        chk("hold cdb_valid", 32'(bus.cdb_o.valid), 32'd0);
        chk("hold cdb_data", bus.cdb_o.data, 32'hDEAD_BEEF);
        chk("hold cdb_tag", 32'(bus.cdb_o.tag), 32'd5);
        chk("hold grant_id", 32'(bus.grant_id_o), 32'd2);
        @(negedge clk);
        drive(1, 0, 4'b1010, 16'h3020);
        #1;
        chk("rr_ptr3 ready", 32'(bus.req_ready), 32'b1000);
        @(posedge clk);
        #1;
        chk("rr_ptr3 cdb_tag", 32'(bus.cdb_o.tag), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
